// File: rtl/debounce_pkg.sv
// Shared types and defaults for the button/switch debouncer.
package debounce_pkg;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 1_000_000;  // 10 ms at 100 MHz
  localparam int unsigned DEFAULT_SYNC_STAGES   = 2;

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/debounce_if.sv
// Raw-in / clean-out pair of the debouncer, bundled for benches and wrappers.
interface debounce_if;
  logic bouncey_in;
  logic clean_out;

  modport master (output bouncey_in, input  clean_out);
  modport slave  (input  bouncey_in, output clean_out);
endinterface

// File: rtl/debounce_sync_chain.sv
// SYNC_STAGES-deep flop chain bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst) ff <= '0;
    else      ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/debounce.sv
// Debouncer: clean_out follows the synchronized input only after it has held a
// new level for STABLE_CYCLES consecutive clocks.
module debounce
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic bouncey_in,
  output logic clean_out
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  // The clock that would bring cnt to STABLE_CYCLES is the one that toggles,
  // so cnt itself tops out at STABLE_CYCLES-1 and can never wrap.
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic          sync_q;
  state_e        state;
  logic [CW-1:0] cnt;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bouncey_in),
    .q   (sync_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= STABLE;
      cnt       <= '0;
      clean_out <= 1'b0;
    end else begin
      case (state)
        STABLE: begin
          if (sync_q != clean_out) begin
            state <= PENDING;
            cnt   <= CW'(1);
          end
        end
        PENDING: begin
          if (sync_q == clean_out) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt >= LAST) begin
            clean_out <= sync_q;
            state     <= STABLE;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce: expected clean_out edges (level + cycle) are queued
// by the stimulus and matched by an independent edge monitor.
module tb_debounce;
  localparam int SC  = 16;
  localparam int SS  = 2;
  localparam int LAT = SS + SC;

  logic clk = 1'b0;
  logic rst;

  debounce_if bus ();

  debounce #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bouncey_in (bus.bouncey_in),
    .clean_out  (bus.clean_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic lvl;
    int   cyc;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  logic prev    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input logic l, input int c);
    ev_t e;
    e.lvl = l;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Edge monitor: every clean_out change must match the oldest queued event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en && (bus.clean_out !== prev)) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_edge: got level %0d with no event queued at cycle %0d",
                   bus.clean_out, cyc);
        end else begin
          e = exp_q.pop_front();
          check("edge_level", {31'd0, bus.clean_out}, {31'd0, e.lvl});
          check("edge_cycle", cyc, e.cyc);
        end
        prev = bus.clean_out;
      end
    end
  end

  initial begin
    logic pat [5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with input already high
    rst = 1'b0;
    bus.bouncey_in = 1'b1;
    tick(1); check("rst_hold0", {31'd0, bus.clean_out}, 0);
    tick(1); check("rst_hold1", {31'd0, bus.clean_out}, 0);
    rst = 1'b1;
    mon_en = 1'b1;
    expect_ev(1'b1, cyc + LAT);
    tick(LAT + 6);
    check("after_reset_high", {31'd0, bus.clean_out}, 1);

    // Release to steady 0
    bus.bouncey_in = 1'b0;
    expect_ev(1'b0, cyc + LAT);
    tick(LAT + 6);

    // Short press is filtered
    bus.bouncey_in = 1'b1;
    tick(5);
    bus.bouncey_in = 1'b0;
    tick(40);
    check("short_press", {31'd0, bus.clean_out}, 0);

    // Bounce train, then steady 1: rise counted from the last 0->1 edge
    for (int i = 0; i < 5; i++) begin
      bus.bouncey_in = pat[i];
      tick(3);
    end
    bus.bouncey_in = 1'b1;
    expect_ev(1'b1, cyc + LAT);
    tick(LAT + 6);

    // One clock short of the threshold: no fall
    bus.bouncey_in = 1'b0;
    tick(SC - 1);
    bus.bouncey_in = 1'b1;
    tick(40);
    check("pulse15_no_fall", {31'd0, bus.clean_out}, 1);

    // Exactly at the threshold: falls, then rises again
    bus.bouncey_in = 1'b0;
    expect_ev(1'b0, cyc + LAT);
    tick(SC);
    bus.bouncey_in = 1'b1;
    expect_ev(1'b1, cyc + LAT);
    tick(LAT + 6);

    // Reset while output high clears it next clock, then full latency again
    rst = 1'b0;
    expect_ev(1'b0, cyc + 1);
    tick(1);
    check("rst_clears_out", {31'd0, bus.clean_out}, 0);
    rst = 1'b1;
    expect_ev(1'b1, cyc + LAT);
    tick(LAT + 6);

    // Reset in the middle of a pending rise restarts the count
    bus.bouncey_in = 1'b0;
    expect_ev(1'b0, cyc + LAT);
    tick(LAT + 6);
    bus.bouncey_in = 1'b1;
    tick(10);
    rst = 1'b0;
    tick(1);
    check("rst_mid_pending", {31'd0, bus.clean_out}, 0);
    rst = 1'b1;
    expect_ev(1'b1, cyc + LAT);
    tick(LAT + 6);
    check("final_level", {31'd0, bus.clean_out}, 1);

    tick(5);
    check("missing_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
